// File: rtl/uart_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_fifo_pkg                                           |
// | Brief    : Shared constants, poll-FSM encoding and status packing   |
// |            for the UART FIFO bridge.                                |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package uart_fifo_pkg;

   // CPU status word bit positions
   localparam int c_STAT_TX_FULL    = 15;
   localparam int c_STAT_RX_NONEMPTY = 14;
   localparam int c_STAT_TX_EMPTY   = 13;
   localparam int c_STAT_RX_FULL    = 12;
   localparam int c_STAT_TX_OVF     = 11;
   localparam int c_STAT_RX_LVL_LSB = 4;
   localparam int c_STAT_TX_LVL_LSB = 0;

   // UART register map, status read
   localparam int c_UART_TX_BUSY = 15;
   localparam int c_UART_RX_FULL = 14;

   typedef enum logic [1:0] {
      POLL = 2'd0,
      RX   = 2'd1,
      TX   = 2'd2
   } poll_state_t;

   function automatic logic [15:0] status_word(
      input logic       tx_full,
      input logic       rx_nonempty,
      input logic       tx_empty,
      input logic       rx_full,
      input logic       tx_ovf,
      input logic [3:0] rx_level,
      input logic [3:0] tx_level
   );
      logic [15:0] s;
      s = 16'h0000;
      s[c_STAT_TX_FULL]              = tx_full;
      s[c_STAT_RX_NONEMPTY]          = rx_nonempty;
      s[c_STAT_TX_EMPTY]             = tx_empty;
      s[c_STAT_RX_FULL]              = rx_full;
      s[c_STAT_TX_OVF]               = tx_ovf;
      s[c_STAT_RX_LVL_LSB +: 4]      = rx_level;
      s[c_STAT_TX_LVL_LSB +: 4]      = tx_level;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : byte_fifo                                               |
// | Brief    : Synchronous 8-bit FIFO with level count; a pop on a     |
// |            full FIFO frees the slot for a same-cycle push.         |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module byte_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          reset_b,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam logic [AW:0] c_FULL_LEVEL = DEPTH[AW:0];

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_pop  = pop && (r_level != '0);
   assign w_do_push = push && ((r_level != c_FULL_LEVEL) || w_do_pop);

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_do_push && !w_do_pop)
            r_level <= r_level + 1'b1;
         else if (!w_do_push && w_do_pop)
            r_level <= r_level - 1'b1;
      end
   end

   // Storage is not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (reset_b && w_do_push) r_mem[r_wptr] <= wdata;
   end

   assign rdata = r_mem[r_rptr];
   assign full  = (r_level == c_FULL_LEVEL);
   assign empty = (r_level == '0);
   assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_fifo_bridge                                        |
// | Brief    : CPU-side TX/RX FIFOs with a poll FSM that shuttles      |
// |            bytes to and from the UART register port.               |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module uart_fifo_bridge
   import uart_fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic [15:0] din,
   output logic [15:0] dout,
   input  logic        a0,
   input  logic        rnw,
   input  logic        cs_b,
   output logic [15:0] u_din,
   input  logic [15:0] u_dout,
   output logic        u_a0,
   output logic        u_rnw,
   output logic        u_cs_b
);

   poll_state_t r_state;
   poll_state_t w_next_state;
   logic        r_tx_ovf;

   logic        w_cpu_wr_data;
   logic        w_cpu_rd_data;
   logic        w_cpu_rd_stat;
   logic        w_tx_pop;
   logic        w_rx_push;
   logic        w_tx_drop;

   logic [7:0]  w_tx_rdata;
   logic        w_tx_full;
   logic        w_tx_empty;
   logic [AW:0] w_tx_level;
   logic [7:0]  w_rx_rdata;
   logic        w_rx_full;
   logic        w_rx_empty;
   logic [AW:0] w_rx_level;
   logic        w_unused;

   assign w_cpu_wr_data = !cs_b && !rnw && a0;
   assign w_cpu_rd_data = !cs_b &&  rnw && a0;
   assign w_cpu_rd_stat = !cs_b &&  rnw && !a0;
   assign w_tx_pop      = (r_state == TX);
   assign w_rx_push     = (r_state == RX);
   // A pop in the same cycle frees a slot, so a write to a full FIFO is kept.
   assign w_tx_drop     = w_cpu_wr_data && w_tx_full && !w_tx_pop;

   byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
      .clk     (clk),
      .reset_b (reset_b),
      .push    (w_cpu_wr_data),
      .pop     (w_tx_pop),
      .wdata   (din[7:0]),
      .rdata   (w_tx_rdata),
      .full    (w_tx_full),
      .empty   (w_tx_empty),
      .level   (w_tx_level)
   );

   byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
      .clk     (clk),
      .reset_b (reset_b),
      .push    (w_rx_push),
      .pop     (w_cpu_rd_data),
      .wdata   (u_dout[7:0]),
      .rdata   (w_rx_rdata),
      .full    (w_rx_full),
      .empty   (w_rx_empty),
      .level   (w_rx_level)
   );

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         r_state  <= POLL;
         r_tx_ovf <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_tx_drop)
            r_tx_ovf <= 1'b1;
         else if (w_cpu_rd_stat)
            r_tx_ovf <= 1'b0;
      end
   end

   always_comb begin
      w_next_state = POLL;
      u_a0         = 1'b0;
      u_rnw        = 1'b1;
      case (r_state)
         POLL: begin
            if (u_dout[c_UART_RX_FULL] && !w_rx_full)
               w_next_state = RX;
            else if (!u_dout[c_UART_TX_BUSY] && !w_tx_empty)
               w_next_state = TX;
         end
         RX: u_a0 = 1'b1;
         TX: begin
            u_a0  = 1'b1;
            u_rnw = 1'b0;
         end
         default: w_next_state = POLL;
      endcase
   end

   assign u_cs_b = !reset_b;
   assign u_din  = {8'h00, w_tx_rdata};

   // Reset forces the empty-FIFO view before the first reset edge lands.
   always_comb begin
      dout = 16'h0000;
      if (!reset_b)
         dout = a0 ? 16'h0000
                   : status_word(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      else if (a0)
         dout = {8'h00, (w_rx_empty ? 8'h00 : w_rx_rdata)};
      else
         dout = status_word(w_tx_full, !w_rx_empty, w_tx_empty, w_rx_full,
                            r_tx_ovf, 4'(w_rx_level), 4'(w_tx_level));
   end

   assign w_unused = &{1'b0, din[15:8], u_dout[13:8]};

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_uart_fifo_bridge                                     |
// | Brief    : Self-checking bench: vector table, directed corner      |
// |            sequences and random traffic against a queue model.     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_uart_fifo_bridge;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_b = 1'b0;
   logic [15:0] din = 16'h0000;
   logic [15:0] dout;
   logic        a0 = 1'b0;
   logic        rnw = 1'b1;
   logic        cs_b = 1'b1;
   logic [15:0] u_din;
   logic [15:0] u_dout;
   logic        u_a0;
   logic        u_rnw;
   logic        u_cs_b;

   uart_fifo_bridge #(.DEPTH(DEPTH), .AW(3)) dut (
      .clk     (clk),
      .reset_b (reset_b),
      .din     (din),
      .dout    (dout),
      .a0      (a0),
      .rnw     (rnw),
      .cs_b    (cs_b),
      .u_din   (u_din),
      .u_dout  (u_dout),
      .u_a0    (u_a0),
      .u_rnw   (u_rnw),
      .u_cs_b  (u_cs_b)
   );

   always #5 clk = ~clk;

   // UART register-port model
   logic        m_busy = 1'b0;
   logic        m_rxf = 1'b0;
   logic [7:0]  m_rxb = 8'h00;
   logic        inj = 1'b0;
   logic [7:0]  inj_byte = 8'h00;
   logic [15:0] wr_log[$];
   int          rd_strobes = 0;

   assign u_dout = {m_busy, m_rxf, 6'b000000, m_rxb};

   always @(posedge clk) begin
      if (!u_cs_b && u_a0 && !u_rnw) wr_log.push_back(u_din);
      if (!u_cs_b && u_a0 && u_rnw) begin
         rd_strobes++;
         m_rxf <= 1'b0;
      end
      if (inj) begin
         m_rxf <= 1'b1;
         m_rxb <= inj_byte;
      end
   end

   // Reference model: two byte queues, overflow flag, poll phase
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   bit         ovf = 1'b0;
   int         mode = 0;   // 0 poll, 1 rx transfer, 2 tx transfer

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        cs_b;
      logic        rnw;
      logic        a0;
      logic [7:0]  data;
      logic [15:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_status();
      logic [15:0] s;
      s = 16'h0000;
      s[15]   = (txq.size() == DEPTH);
      s[14]   = (rxq.size() != 0);
      s[13]   = (txq.size() == 0);
      s[12]   = (rxq.size() == DEPTH);
      s[11]   = ovf;
      s[7:4]  = 4'(rxq.size());
      s[3:0]  = 4'(txq.size());
      return s;
   endfunction

   task automatic set_cpu(input logic c, input logic r, input logic a, input logic [7:0] d);
      cs_b = c;
      rnw  = r;
      a0   = a;
      din  = {8'hC3, d};
   endtask

   task automatic cpu_idle();
      set_cpu(1'b1, 1'b1, 1'b0, 8'h00);
   endtask

   // One clock: compare outputs mid-cycle, then advance the model past the edge.
   task automatic tick();
      logic [15:0] exp_dout;
      logic        busy_s;
      logic        rxf_s;
      logic [7:0]  rxb_s;
      int          nm;
      bit          set_ovf;
      int          tx_pre;
      int          rx_pre;
      @(negedge clk);
      busy_s = m_busy;
      rxf_s  = m_rxf;
      rxb_s  = m_rxb;
      if (!reset_b)
         exp_dout = a0 ? 16'h0000 : 16'h2000;
      else if (a0)
         exp_dout = (rxq.size() != 0) ? {8'h00, rxq[0]} : 16'h0000;
      else
         exp_dout = model_status();
      check("dout", dout, exp_dout);
      if (!reset_b) begin
         check("u_cs_b_in_reset", {15'd0, u_cs_b}, 16'd1);
      end else if (mode == 0) begin
         check("poll_strobe", {13'd0, u_cs_b, u_rnw, u_a0}, 16'b010);
      end else if (mode == 1) begin
         check("rx_strobe", {13'd0, u_cs_b, u_rnw, u_a0}, 16'b011);
      end else begin
         check("tx_strobe", {13'd0, u_cs_b, u_rnw, u_a0}, 16'b001);
         if (txq.size() != 0) check("tx_u_din", u_din, {8'h00, txq[0]});
      end
      @(posedge clk);
      #1;
      if (!reset_b) begin
         txq.delete();
         rxq.delete();
         ovf  = 1'b0;
         mode = 0;
      end else begin
         tx_pre  = txq.size();
         rx_pre  = rxq.size();
         set_ovf = 1'b0;
         nm      = 0;
         if (mode == 0) begin
            if (rxf_s && rx_pre < DEPTH) nm = 1;
            else if (!busy_s && tx_pre > 0) nm = 2;
         end
         if (mode == 2 && txq.size() != 0) void'(txq.pop_front());
         if (!cs_b && !rnw && a0) begin
            if (txq.size() < DEPTH) txq.push_back(din[7:0]);
            else set_ovf = 1'b1;
         end
         if (!cs_b && rnw && a0 && rxq.size() != 0) void'(rxq.pop_front());
         if (mode == 1) rxq.push_back(rxb_s);
         if (set_ovf) ovf = 1'b1;
         else if (!cs_b && rnw && !a0) ovf = 1'b0;
         mode = nm;
      end
   endtask

   task automatic expect_status(input string name, input logic [15:0] exp);
      cpu_idle();
      #1;
      check(name, dout, exp);
   endtask

   task automatic inject(input logic [7:0] b);
      inj      = 1'b1;
      inj_byte = b;
      tick();
      inj      = 1'b0;
   endtask

   initial begin
      vec_t vt[14];
      int   cnt;
      int   s0;
      int   op;

      // ---- reset ----
      m_busy  = 1'b1;
      reset_b = 1'b0;
      cpu_idle();
      tick();
      tick();
      #1;
      check("reset_status", dout, 16'h2000);
      check("reset_u_cs_b", {15'd0, u_cs_b}, 16'd1);
      reset_b = 1'b1;
      tick();
      check("poll_after_reset", {13'd0, u_cs_b, u_rnw, u_a0}, 16'b010);

      // ---- vector table: TX fill and overflow with UART busy ----
      vt[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h2000};
      for (int i = 1; i <= 9; i++) vt[i] = '{1'b0, 1'b0, 1'b1, 8'(i), 16'h0000};
      vt[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h8808};
      vt[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h8008};
      vt[12] = '{1'b0, 1'b0, 1'b0, 8'hFF, 16'h8008};
      vt[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h8008};
      for (int i = 0; i < 14; i++) begin
         set_cpu(vt[i].cs_b, vt[i].rnw, vt[i].a0, vt[i].data);
         #1;
         check($sformatf("vec%0d", i), dout, vt[i].exp);
         tick();
      end

      // ---- release busy; push into full TX FIFO while it pops ----
      cpu_idle();
      m_busy = 1'b0;
      wr_log.delete();
      tick();
      set_cpu(1'b0, 1'b0, 1'b1, 8'h0A);
      tick();
      set_cpu(1'b0, 1'b1, 1'b0, 8'h00);
      #1;
      check("full_push_pop_status", dout, 16'h8008);
      tick();
      cpu_idle();
      cnt = 0;
      while (wr_log.size() < 9 && cnt < 40) begin
         tick();
         cnt++;
      end
      check("drain_count", 16'(wr_log.size()), 16'd9);
      for (int k = 0; k < 9; k++)
         check($sformatf("drain_byte%0d", k), (wr_log.size() > k) ? wr_log[k] : 16'hFFFF,
               (k < 8) ? 16'(k + 1) : 16'h000A);
      expect_status("drained_status", 16'h2000);

      // ---- single byte with idle UART ----
      wr_log.delete();
      set_cpu(1'b0, 1'b0, 1'b1, 8'h55);
      tick();
      cpu_idle();
      cnt = 0;
      while (wr_log.size() == 0 && cnt < 3) begin
         tick();
         cnt++;
      end
      check("tx55_count", 16'(wr_log.size()), 16'd1);
      check("tx55_data", (wr_log.size() != 0) ? wr_log[0] : 16'hFFFF, 16'h0055);
      expect_status("tx55_level", 16'h2000);

      // ---- single RX byte ----
      s0 = rd_strobes;
      inject(8'hA5);
      cnt = 0;
      while (rd_strobes == s0 && cnt < 4) begin
         tick();
         cnt++;
      end
      check("rx_a5_strobe", 16'(rd_strobes - s0), 16'd1);
      expect_status("rx_level1", 16'h6010);
      set_cpu(1'b0, 1'b1, 1'b1, 8'h00);
      #1;
      check("rx_a5_data", dout, 16'h00A5);
      tick();
      expect_status("rx_level0", 16'h2000);
      tick();
      tick();
      check("rx_a5_single", 16'(rd_strobes - s0), 16'd1);

      // ---- fill RX FIFO, ninth byte held in the UART ----
      s0 = rd_strobes;
      for (int i = 0; i < 8; i++) begin
         inject(8'h11 + 8'(i));
         cnt = 0;
         while (m_rxf && cnt < 6) begin
            tick();
            cnt++;
         end
      end
      check("rx8_strobes", 16'(rd_strobes - s0), 16'd8);
      expect_status("rx_full_status", 16'h7080);
      inject(8'h19);
      repeat (6) tick();
      check("rx9_pending", {15'd0, m_rxf}, 16'd1);
      check("rx9_no_strobe", 16'(rd_strobes - s0), 16'd8);
      set_cpu(1'b0, 1'b1, 1'b1, 8'h00);
      #1;
      check("rx_pop_head", dout, 16'h0011);
      tick();
      cpu_idle();
      cnt = 0;
      while (m_rxf && cnt < 6) begin
         tick();
         cnt++;
      end
      check("rx9_accepted", 16'(rd_strobes - s0), 16'd9);
      expect_status("rx_full_again", 16'h7080);
      for (int i = 0; i < 8; i++) begin
         set_cpu(1'b0, 1'b1, 1'b1, 8'h00);
         #1;
         check($sformatf("rx_order%0d", i), dout, 16'h0012 + 16'(i));
         tick();
      end
      expect_status("rx_empty_end", 16'h2000);

      // ---- random traffic against the model ----
      for (int c = 0; c < 3000; c++) begin
         reset_b  = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         m_busy   = 1'($urandom_range(0, 1));
         inj      = (!m_rxf && $urandom_range(0, 3) == 0) || ($urandom_range(0, 31) == 0);
         inj_byte = 8'($urandom);
         op       = $urandom_range(0, 6);
         case (op)
            0:       cpu_idle();
            1, 2:    set_cpu(1'b0, 1'b0, 1'b1, 8'($urandom));
            3, 4:    set_cpu(1'b0, 1'b1, 1'b1, 8'h00);
            5:       set_cpu(1'b0, 1'b1, 1'b0, 8'h00);
            default: set_cpu(1'b0, 1'b0, 1'b0, 8'($urandom));
         endcase
         tick();
      end
      inj     = 1'b0;
      reset_b = 1'b1;
      cpu_idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
